slc3_mem_bridge: RTL and testbench

Memory and I/O bridge between the SLC-3 control/datapath and the on-chip synchronous block RAM. It turns the control unit's three-cycle `mem_mem_ena` / `mem_wr_ena` strobe windows into one BRAM or memory-mapped I/O access. Reads return data aligned to the final wait-state cycle, so MDR loads the correct word on that cycle's closing edge. It also owns the memory-mapped switch input and hex-display register at `IO_ADDR`.

---
 rtl/slc3_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/slc3_mem_bridge.sv | 131 +++++++++++++
 tb/tb_slc3_mem_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared SLC-3 definitions: memory-bridge FSM states, I/O port address and
// the number of control-unit wait states per memory access.
package slc3_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int unsigned MEM_WAIT        = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4
    } mem_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Ports: clk, reset (async active-low), d (async input), q (synchronised output).
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/slc3_mem_bridge.sv
// Bridge between the SLC-3 control/datapath and a synchronous BRAM (2-edge
// read latency) plus one memory-mapped I/O word (switches in, hex display out).
// Ports: clk, reset (async active-low); mem_mem_ena/mem_wr_ena/mar/mdr from
// control; mem_rdata/mem_rvalid/busy back to datapath; bram_* to the BRAM;
// sw_i raw switches; hex_o display register.
module slc3_mem_bridge
    import slc3_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter logic [15:0] IO_ADDR = IO_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_mem_ena,
    input  logic              mem_wr_ena,
    input  logic [15:0]       mar,
    input  logic [15:0]       mdr,
    output logic [15:0]       mem_rdata,
    output logic              mem_rvalid,
    output logic              busy,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [15:0]       bram_din,
    input  logic [15:0]       bram_dout,
    input  logic [15:0]       sw_i,
    output logic [15:0]       hex_o
);

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic              ena_q;      // previous-cycle sample of mem_mem_ena
    logic              armed;      // mem_mem_ena seen low since reset
    logic              io_q;       // current read targets the I/O port
    logic [DATA_W-1:0] sw_sync;
    logic [DATA_W-1:0] io_pipe;
    logic              io_sel_c;
    logic              accept_c;

    sync_2ff #(.WIDTH(DATA_W)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (sw_i),
        .q     (sw_sync)
    );

    assign io_sel_c = (mar == IO_ADDR);
    // Rising edge only; armed blocks a strobe already high out of reset.
    assign accept_c = (state == IDLE) && mem_mem_ena && !ena_q && armed;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and outputs; BRAM strobes are combinational in the accept cycle
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        bram_ena   = 1'b0;
        bram_wea   = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = mem_wr_ena ? WR1 : RD1;
                    if (!io_sel_c) begin
                        bram_ena  = 1'b1;
                        bram_wea  = mem_wr_ena;
                        bram_addr = ADDR_W'(mar);
                        if (mem_wr_ena) begin
                            bram_din = mdr;
                        end
                    end
                end
            end
            RD1: begin
                busy      = 1'b1;
                state_nxt = RD2;
            end
            RD2: begin
                busy       = 1'b1;
                mem_rvalid = 1'b1;
                mem_rdata  = io_q ? io_pipe : bram_dout;
                state_nxt  = IDLE;
            end
            WR1: begin
                busy      = 1'b1;
                state_nxt = WR2;
            end
            WR2: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge detect, request capture, I/O read pipeline and hex register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ena_q   <= 1'b0;
            armed   <= 1'b0;
            io_q    <= 1'b0;
            io_pipe <= '0;
            hex_o   <= '0;
        end else begin
            ena_q <= mem_mem_ena;
            if (!mem_mem_ena) begin
                armed <= 1'b1;
            end
            if (accept_c) begin
                io_q <= io_sel_c;
                if (io_sel_c && !mem_wr_ena) begin
                    io_pipe <= sw_sync;
                end
                if (io_sel_c && mem_wr_ena) begin
                    hex_o <= mdr;
                end
            end
        end
    end

endmodule

// File: tb/tb_slc3_mem_bridge.sv
`timescale 1ns/1ps
module tb_slc3_mem_bridge;

    localparam int unsigned ADDR_W = 16;

    logic              clk;
    logic              reset;
    logic              mem_mem_ena;
    logic              mem_wr_ena;
    logic [15:0]       mar;
    logic [15:0]       mdr;
    logic [15:0]       mem_rdata;
    logic              mem_rvalid;
    logic              busy;
    logic              bram_ena;
    logic              bram_wea;
    logic [ADDR_W-1:0] bram_addr;
    logic [15:0]       bram_din;
    logic [15:0]       bram_dout;
    logic [15:0]       sw_i;
    logic [15:0]       hex_o;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    slc3_mem_bridge #(.ADDR_W(ADDR_W), .IO_ADDR(16'hFFFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_mem_ena (mem_mem_ena),
        .mem_wr_ena  (mem_wr_ena),
        .mar         (mar),
        .mdr         (mdr),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .busy        (busy),
        .bram_ena    (bram_ena),
        .bram_wea    (bram_wea),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_dout   (bram_dout),
        .sw_i        (sw_i),
        .hex_o       (hex_o)
    );

    // Block RAM with registered output: address sampled on edge 1, data out after edge 2
    logic [15:0] bram_mem [0:65535];
    logic [15:0] bram_rd;
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            bram_mem[pre_addr] <= pre_data;
        end else if (bram_ena) begin
            if (bram_wea) bram_mem[bram_addr] <= bram_din;
            bram_rd <= bram_mem[bram_addr];
        end
        bram_dout <= bram_rd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access timing expressed as cycle offsets from the accept cycle
    logic [15:0] ref_mem [0:65535];
    int          cyc = 0;
    int          acc_cyc = -100;
    int          dd;
    bit          acc_valid = 0;
    bit          m_prev_ena = 0;
    bit          m_seen_low = 0;
    bit          m_acc;
    bit          a_wr, a_io;
    logic [15:0] a_addr, a_mdr, a_data;
    logic [15:0] hex_m = '0;
    logic [15:0] hex_next;
    bit          e_ena, e_wea, e_rv, e_busy, chk_busy;
    logic [15:0] e_addr, e_din, e_rd;

    always @(negedge clk) begin
        if (pre_we) ref_mem[pre_addr] = pre_data;
        if (!reset) begin
            chk("rst_rvalid", 32'(mem_rvalid), 32'd0);
            chk("rst_rdata", 32'(mem_rdata), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_bram_ena", 32'(bram_ena), 32'd0);
            chk("rst_bram_addr", 32'(bram_addr), 32'd0);
            chk("rst_hex", 32'(hex_o), 32'd0);
            acc_valid  = 0;
            m_prev_ena = 0;
            m_seen_low = 0;
            hex_m      = '0;
        end else begin
            hex_next = hex_m;
            dd = cyc - acc_cyc;
            m_acc = !(acc_valid && (dd == 1 || dd == 2)) && m_seen_low
                    && mem_mem_ena && !m_prev_ena;
            if (m_acc) begin
                acc_cyc   = cyc;
                acc_valid = 1;
                dd        = 0;
                a_wr      = mem_wr_ena;
                a_io      = (mar == 16'hFFFF);
                a_addr    = mar;
                a_mdr     = mdr;
                a_data    = a_io ? sw_i : ref_mem[mar];
                if (a_wr) begin
                    if (a_io) hex_next = mdr;
                    else ref_mem[mar] = mdr;
                end
            end
            e_ena = 0; e_wea = 0; e_addr = '0; e_din = '0;
            e_rv = 0; e_rd = '0; e_busy = 0; chk_busy = 1;
            if (acc_valid) begin
                case (dd)
                    0: begin
                        chk_busy = 0;
                        if (!a_io) begin
                            e_ena  = 1;
                            e_wea  = a_wr;
                            e_addr = a_addr;
                            if (a_wr) e_din = a_mdr;
                        end
                    end
                    1: e_busy = 1;
                    2: begin
                        e_busy = 1;
                        e_rv   = !a_wr;
                        if (!a_wr) e_rd = a_data;
                    end
                    default: ;
                endcase
            end
            chk("bram_ena", 32'(bram_ena), 32'(e_ena));
            chk("bram_wea", 32'(bram_wea), 32'(e_wea));
            chk("bram_addr", 32'(bram_addr), 32'(e_addr));
            chk("bram_din", 32'(bram_din), 32'(e_din));
            chk("mem_rvalid", 32'(mem_rvalid), 32'(e_rv));
            chk("mem_rdata", 32'(mem_rdata), 32'(e_rd));
            chk("hex_o", 32'(hex_o), 32'(hex_m));
            if (chk_busy) chk("busy", 32'(busy), 32'(e_busy));
            hex_m      = hex_next;
            m_prev_ena = mem_mem_ena;
            if (!mem_mem_ena) m_seen_low = 1;
        end
        cyc++;
    end

    // One strobe window of `hold` cycles followed by one low cycle
    task automatic strobe(input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input bit wiggle,
                          output logic [15:0] rd2, output int rv2,
                          output int rv_cnt, output int ena_cnt,
                          output int wea_cnt, output int busy_cnt);
        rd2 = '0; rv2 = 0; rv_cnt = 0; ena_cnt = 0; wea_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            mem_mem_ena = 1'b1;
            if (wiggle && i > 0) begin
                mem_wr_ena = ~wr;
                mar        = a ^ 16'h0030;
            end else begin
                mem_wr_ena = wr;
                mar        = a;
                mdr        = d;
            end
            @(negedge clk);
            if (i == 2) begin
                rd2 = mem_rdata;
                rv2 = int'(mem_rvalid);
            end
            rv_cnt   += int'(mem_rvalid);
            ena_cnt  += int'(bram_ena);
            wea_cnt  += int'(bram_wea);
            busy_cnt += int'(busy);
        end
        @(posedge clk); #1;
        mem_mem_ena = 1'b0;
        mem_wr_ena  = 1'b0;
        @(negedge clk);
        rv_cnt   += int'(mem_rvalid);
        ena_cnt  += int'(bram_ena);
        wea_cnt  += int'(bram_wea);
        busy_cnt += int'(busy);
    endtask

    logic [15:0] rd2;
    int          rv2, rvc, enac, weac, busyc;

    initial begin
        reset = 1'b0; mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
        mar = '0; mdr = '0; sw_i = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
        @(posedge clk); #1;
        pre_we = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // BRAM read of preloaded word
        strobe(1'b0, 16'h0010, 16'h0000, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("rd_beef_data_t2", 32'(rd2), 32'h0000BEEF);
        chk("rd_beef_rvalid_t2", 32'(rv2), 32'd1);
        chk("rd_beef_rvalid_cnt", 32'(rvc), 32'd1);
        chk("rd_beef_ena_cnt", 32'(enac), 32'd1);
        chk("rd_beef_busy_cnt", 32'(busyc), 32'd2);

        // BRAM write then read back
        strobe(1'b1, 16'h0020, 16'h1234, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("wr_wea_cnt", 32'(weac), 32'd1);
        chk("wr_rvalid_cnt", 32'(rvc), 32'd0);
        strobe(1'b0, 16'h0020, 16'h0000, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("rd_1234_data_t2", 32'(rd2), 32'h00001234);

        // I/O write to hex display
        strobe(1'b1, 16'hFFFF, 16'h00A5, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("io_wr_ena_cnt", 32'(enac), 32'd0);
        chk("io_wr_hex", 32'(hex_o), 32'h000000A5);

        // Switch read through synchroniser
        sw_i = 16'h5A5A;
        repeat (3) @(posedge clk);
        #1;
        strobe(1'b0, 16'hFFFF, 16'h0000, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("io_rd_data_t2", 32'(rd2), 32'h00005A5A);
        chk("io_rd_ena_cnt", 32'(enac), 32'd0);

        // Address one below the I/O port is ordinary BRAM
        strobe(1'b1, 16'hFFFE, 16'hCAFE, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("fffe_wr_ena_cnt", 32'(enac), 32'd1);
        chk("fffe_hex_kept", 32'(hex_o), 32'h000000A5);
        strobe(1'b0, 16'hFFFE, 16'h0000, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("fffe_rd_data_t2", 32'(rd2), 32'h0000CAFE);

        // Held strobe: exactly one access
        strobe(1'b0, 16'h0010, 16'h0000, 6, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("hold_ena_cnt", 32'(enac), 32'd1);
        chk("hold_rvalid_cnt", 32'(rvc), 32'd1);
        chk("hold_busy_cnt", 32'(busyc), 32'd2);

        // mar/mem_wr_ena change after accept do not disturb the read
        strobe(1'b0, 16'h0020, 16'h0000, 3, 1'b1, rd2, rv2, rvc, enac, weac, busyc);
        chk("wiggle_data_t2", 32'(rd2), 32'h00001234);
        chk("wiggle_wea_cnt", 32'(weac), 32'd0);
        chk("wiggle_rvalid_cnt", 32'(rvc), 32'd1);

        // Reset asserted during RD1
        @(posedge clk); #1;
        mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; mar = 16'h0010;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_rvalid", 32'(mem_rvalid), 32'd0);
        chk("rst_mid_hex", 32'(hex_o), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        rvc = 0; enac = 0; busyc = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rvc   += int'(mem_rvalid);
            enac  += int'(bram_ena);
            busyc += int'(busy);
        end
        chk("post_rst_held_ena", 32'(enac), 32'd0);
        chk("post_rst_held_rvalid", 32'(rvc), 32'd0);
        chk("post_rst_held_busy", 32'(busyc), 32'd0);
        @(posedge clk); #1;
        mem_mem_ena = 1'b0;
        strobe(1'b0, 16'h0010, 16'h0000, 3, 1'b0, rd2, rv2, rvc, enac, weac, busyc);
        chk("post_rst_rd_data_t2", 32'(rd2), 32'h0000BEEF);
        chk("post_rst_rd_ena_cnt", 32'(enac), 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
